// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: issues loads/stores over a req/ack handshake, stalls EX while a request is
// outstanding, and registers the WB bundle. Define MEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module mem_stage_unit #(
  parameter  int DATA_W  = 64,
  parameter  int INSTR_W = 32,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic               memreg,
  input  logic [1:0]         xfer_size,
  input  logic               sign_ext,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [BE_W-1:0]    dmem_be,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               mem_valid,
  output logic [INSTR_W-1:0] mem_instr,
  output logic [DATA_W-1:0]  mem_alu_result,
  output logic [DATA_W-1:0]  mem_load_data,
  output logic [DATA_W-1:0]  mem_wb_data,
  output logic               mem_fault,
  output logic [DATA_W-1:0]  fwd_data
);

  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t state_reg, state_next;

  // Request context captured when entering REQ
  logic [INSTR_W-1:0] instr_reg;
  logic [DATA_W-1:0]  alu_reg;
  logic [OFF_W-1:0]   off_reg;
  logic [3:0]         nbytes_reg;
  logic               sext_reg;
  logic               memreg_reg;
  logic               load_reg;
  logic               fault_reg;

  // EX-side request decode
  logic [1:0]       size_eff;
  logic [3:0]       nbytes;
  logic [OFF_W-1:0] off_raw;
  logic [OFF_W-1:0] off_eff;
  logic [OFF_W-1:0] size_mask;
  logic             trap_now;
  logic             mem_access;
  logic [BE_W-1:0]  be_calc;
  logic [DATA_W-1:0] addr_calc;
  logic [DATA_W-1:0] wdata_calc;

  // Load return path
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic              sign_bit;

  assign mem_access = rd_en | wr_en;
  assign size_eff   = (DATA_W == 32 && xfer_size == 2'd3) ? 2'd2 : xfer_size;
  assign nbytes     = 4'd1 << size_eff;
  assign off_raw    = ex_alu_result[OFF_W-1:0];
  assign size_mask  = OFF_W'(nbytes - 4'd1);

`ifdef MEM_MISALIGN_TRAP_EN
  assign off_eff  = off_raw;
  assign trap_now = mem_access && ((off_raw & size_mask) != '0);
`else
  // Misaligned offsets are rounded down to the access size
  assign off_eff  = off_raw & ~size_mask;
  assign trap_now = 1'b0;
`endif

  assign addr_calc  = {ex_alu_result[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
  assign wdata_calc = ex_store_data << {off_eff, 3'b000};

  always_comb begin
    be_calc = '0;
    for (int i = 0; i < BE_W; i++) begin
      be_calc[i] = (i >= int'(off_eff)) && (i < int'(off_eff) + int'(nbytes));
    end
  end

  always_comb begin
    shifted  = dmem_rdata >> {off_reg, 3'b000};
    sign_bit = shifted[8 * int'(nbytes_reg) - 1];
    load_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < 8 * int'(nbytes_reg)) ? shifted[i] : (sext_reg & sign_bit);
    end
  end

  always_comb begin
    state_next = state_reg;
    ex_ready   = (state_reg == IDLE);
    case (state_reg)
      IDLE: if (ex_valid && mem_access && !trap_now) state_next = REQ;
      REQ:  if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // dmem_req follows the state register so reset withdraws it immediately
  assign dmem_req  = (state_reg == REQ);
  assign mem_fault = fault_reg;
  assign fwd_data  = mem_wb_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      instr_reg      <= '0;
      alu_reg        <= '0;
      off_reg        <= '0;
      nbytes_reg     <= 4'd1;
      sext_reg       <= 1'b0;
      memreg_reg     <= 1'b0;
      load_reg       <= 1'b0;
      mem_valid      <= 1'b0;
      mem_instr      <= '0;
      mem_alu_result <= '0;
      mem_load_data  <= '0;
      mem_wb_data    <= '0;
      fault_reg      <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ex_valid) begin
            if (!mem_access) begin
              mem_valid      <= 1'b1;
              mem_instr      <= ex_instr;
              mem_alu_result <= ex_alu_result;
              mem_load_data  <= '0;
              mem_wb_data    <= memreg ? '0 : ex_alu_result;
              fault_reg      <= 1'b0;
            end else if (trap_now) begin
              mem_valid      <= 1'b1;
              mem_instr      <= ex_instr;
              mem_alu_result <= ex_alu_result;
              mem_load_data  <= '0;
              mem_wb_data    <= '0;
              fault_reg      <= 1'b1;
            end else begin
              dmem_we    <= wr_en;
              dmem_addr  <= addr_calc;
              dmem_be    <= be_calc;
              dmem_wdata <= wdata_calc;
              instr_reg  <= ex_instr;
              alu_reg    <= ex_alu_result;
              off_reg    <= off_eff;
              nbytes_reg <= nbytes;
              sext_reg   <= sign_ext;
              memreg_reg <= memreg;
              load_reg   <= rd_en & ~wr_en;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            mem_valid      <= 1'b1;
            mem_instr      <= instr_reg;
            mem_alu_result <= alu_reg;
            mem_load_data  <= load_reg ? load_ext : '0;
            mem_wb_data    <= memreg_reg ? (load_reg ? load_ext : '0) : alu_reg;
            fault_reg      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Table-driven bench for mem_stage_unit (DATA_W=64) with a scoreboard of expected WB bundles,
// plus hand-written reset-in-REQ and idle-hold sequences.
module tb_mem_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_instr;
  logic [63:0] ex_alu_result, ex_store_data;
  logic        rd_en, wr_en, memreg, sign_ext;
  logic [1:0]  xfer_size;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic        mem_valid, mem_fault;
  logic [31:0] mem_instr;
  logic [63:0] mem_alu_result, mem_load_data, mem_wb_data, fwd_data;

  int checks = 0;
  int failures = 0;

  mem_stage_unit #(.DATA_W(64), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .rd_en(rd_en), .wr_en(wr_en), .memreg(memreg), .xfer_size(xfer_size), .sign_ext(sign_ext),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_wb_data(mem_wb_data), .mem_fault(mem_fault),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] alu;
    logic [63:0] sdata;
    logic        rd;
    logic        wr;
    logic        mreg;
    logic [1:0]  size;
    logic        sext;
    logic [63:0] rdata;
    int          ack_dly;
    logic        is_mem;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] load;
    logic [63:0] wb;
    logic        fault;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] alu;
    logic [63:0] load;
    logic [63:0] wb;
    logic        fault;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  logic [63:0] last_wb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    chk("mem_valid", {63'd0, mem_valid}, 64'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("mem_instr", {32'd0, mem_instr}, {32'd0, e.instr});
      chk("mem_alu_result", mem_alu_result, e.alu);
      chk("mem_load_data", mem_load_data, e.load);
      chk("mem_wb_data", mem_wb_data, e.wb);
      chk("mem_fault", {63'd0, mem_fault}, {63'd0, e.fault});
      chk("fwd_data", fwd_data, e.wb);
      last_wb = e.wb;
    end
  endtask

  task automatic apply(input int idx);
    vec_t v;
    exp_t e;
    v = tbl[idx];
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = v.instr; ex_alu_result = v.alu; ex_store_data = v.sdata;
    rd_en = v.rd; wr_en = v.wr; memreg = v.mreg; xfer_size = v.size; sign_ext = v.sext;
    e.instr = v.instr; e.alu = v.alu; e.load = v.load; e.wb = v.wb; e.fault = v.fault;
    sb.push_back(e);
    @(negedge clk);
    if (v.is_mem) begin
      // Keep EX presenting junk while stalled; it must not be taken
      ex_alu_result = 64'hFFFF_0000_FFFF_0007; ex_store_data = 64'h0BAD_0BAD_0BAD_0BAD;
      chk("dmem_req", {63'd0, dmem_req}, 64'd1);
      chk("dmem_we", {63'd0, dmem_we}, {63'd0, v.we});
      chk("dmem_addr", dmem_addr, v.addr);
      chk("dmem_be", {56'd0, dmem_be}, {56'd0, v.be});
      chk("dmem_wdata", dmem_wdata, v.wdata);
      chk("ex_ready_stall", {63'd0, ex_ready}, 64'd0);
      chk("mem_valid_req", {63'd0, mem_valid}, 64'd0);
      for (int k = 1; k < v.ack_dly; k++) begin
        @(negedge clk);
        chk("dmem_addr_hold", dmem_addr, v.addr);
        chk("dmem_req_hold", {63'd0, dmem_req}, 64'd1);
        chk("mem_valid_wait", {63'd0, mem_valid}, 64'd0);
      end
      dmem_ack = 1'b1; dmem_rdata = v.rdata; ex_valid = 1'b0;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 64'h0;
      chk("dmem_req_done", {63'd0, dmem_req}, 64'd0);
      chk("ex_ready_done", {63'd0, ex_ready}, 64'd1);
      compare_pop();
    end else begin
      ex_valid = 1'b0;
      chk("dmem_req_none", {63'd0, dmem_req}, 64'd0);
      chk("ex_ready_idle", {63'd0, ex_ready}, 64'd1);
      compare_pop();
    end
    @(negedge clk);
    chk("mem_valid_pulse", {63'd0, mem_valid}, 64'd0);
    chk("mem_wb_hold", mem_wb_data, last_wb);
    $display("txn %0d instr=%h wb=%h load=%h fault=%0b", idx, mem_instr, mem_wb_data,
             mem_load_data, mem_fault);
  endtask

  initial begin
    //          instr         alu          sdata        rd    wr    mreg  size  sext  rdata                  ack is_mem we    addr         be     wdata                  load                   wb                     fault
    tbl[0] = '{32'hA0000001, 64'h1234, 64'h0,        1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 64'h0,                 0, 1'b0, 1'b0, 64'h0,   8'h00, 64'h0,                 64'h0,                 64'h1234,              1'b0};
    tbl[1] = '{32'hF8400001, 64'h100,  64'h0,        1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 64'h1122334455667788,  3, 1'b1, 1'b0, 64'h100, 8'hFF, 64'h0,                 64'h1122334455667788,  64'h1122334455667788,  1'b0};
    tbl[2] = '{32'h38800002, 64'h103,  64'h0,        1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 64'h0000000080000000,  1, 1'b1, 1'b0, 64'h100, 8'h08, 64'h0,                 64'hFFFFFFFFFFFFFF80,  64'hFFFFFFFFFFFFFF80,  1'b0};
    tbl[3] = '{32'h78000003, 64'h106,  64'hBEEF,     1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 64'hDEADDEADDEADDEAD,  2, 1'b1, 1'b1, 64'h100, 8'hC0, 64'hBEEF000000000000,  64'h0,                 64'h106,               1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
    tbl[4] = '{32'hB8800004, 64'h102,  64'h0,        1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 64'hAABBCCDD8899EEFF,  0, 1'b0, 1'b0, 64'h0,   8'h00, 64'h0,                 64'h0,                 64'h0,                 1'b1};
`else
    tbl[4] = '{32'hB8800004, 64'h102,  64'h0,        1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 64'hAABBCCDD8899EEFF,  2, 1'b1, 1'b0, 64'h100, 8'h0F, 64'h0,                 64'hFFFFFFFF8899EEFF,  64'hFFFFFFFF8899EEFF,  1'b0};
`endif
    tbl[5] = '{32'h78400005, 64'h10A,  64'h0,        1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h00000000CAFE0000,  1, 1'b1, 1'b0, 64'h108, 8'h0C, 64'h0,                 64'hCAFE,              64'hCAFE,              1'b0};
    tbl[6] = '{32'hB8000006, 64'h104,  64'h12345678, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 64'hFFFFFFFFFFFFFFFF,  4, 1'b1, 1'b1, 64'h100, 8'hF0, 64'h1234567800000000,  64'h0,                 64'h0,                 1'b0};
    tbl[7] = '{32'h38400007, 64'h101,  64'h55,       1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 64'h000000000000AB00,  2, 1'b1, 1'b0, 64'h100, 8'h02, 64'h5500,              64'hFFFFFFFFFFFFFFAB,  64'h101,               1'b0};

    reset = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_alu_result = '0; ex_store_data = '0;
    rd_en = 1'b0; wr_en = 1'b0; memreg = 1'b0; xfer_size = 2'd0; sign_ext = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0; last_wb = '0;
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_dmem_be", {56'd0, dmem_be}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_mem_wb_data", mem_wb_data, 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) apply(i);

    // Reset while a request is outstanding, followed by a stray ack
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = 32'hF8400009; ex_alu_result = 64'h200; rd_en = 1'b1; wr_en = 1'b0;
    memreg = 1'b1; xfer_size = 2'd3; sign_ext = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("abort_req_up", {63'd0, dmem_req}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("abort_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("abort_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("abort_wb_clear", mem_wb_data, 64'd0);
    @(negedge clk);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'h0123456789ABCDEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_valid", {63'd0, mem_valid}, 64'd0);
    chk("late_ack_req", {63'd0, dmem_req}, 64'd0);
    @(negedge clk);
    chk("late_ack_valid2", {63'd0, mem_valid}, 64'd0);
    chk("late_ack_wb", mem_wb_data, 64'd0);
    $display("txn abort wb=%h valid=%0b", mem_wb_data, mem_valid);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
